// File: rtl/btn_input_ctrl.sv
// Multi-channel button front end: two-flop synchroniser, debounce, and press/release/
// long-press/auto-repeat strobes per channel, all channels fully independent.

module btn_input_ctrl_chk #(
    parameter int NUM_CH = 2
) (
    input logic              i_clk,
    input logic              i_rst,
    input logic [NUM_CH-1:0] o_btn,
    input logic [NUM_CH-1:0] o_press,
    input logic [NUM_CH-1:0] o_release,
    input logic [NUM_CH-1:0] o_long,
    input logic [NUM_CH-1:0] o_repeat
);
    localparam logic [NUM_CH-1:0] ZERO = {NUM_CH{1'b0}};

    a_press_level : assert property (@(posedge i_clk) disable iff (i_rst)
        ((o_press & ~o_btn) == ZERO));
    a_release_level : assert property (@(posedge i_clk) disable iff (i_rst)
        ((o_release & o_btn) == ZERO));
    a_hold_level : assert property (@(posedge i_clk) disable iff (i_rst)
        (((o_long | o_repeat) & ~o_btn) == ZERO));
    a_press_exclusive : assert property (@(posedge i_clk) disable iff (i_rst)
        ((o_press & (o_long | o_repeat | o_release)) == ZERO));
    a_long_repeat_exclusive : assert property (@(posedge i_clk) disable iff (i_rst)
        ((o_long & o_repeat) == ZERO));
endmodule

module btn_input_ctrl #(
    parameter int NUM_CH          = 2,
    parameter int MIN_PULSE_WIDTH = 25000,
    parameter int IN_ACTIVE_LOW   = 1,
    parameter int LONG_PRESS      = 12500000,
    parameter int REPEAT_INTERVAL = 2500000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_btn,
    output logic [NUM_CH-1:0] o_btn,
    output logic [NUM_CH-1:0] o_press,
    output logic [NUM_CH-1:0] o_release,
    output logic [NUM_CH-1:0] o_long,
    output logic [NUM_CH-1:0] o_repeat,
    output logic              o_any
);
    localparam int DB_W     = $clog2(MIN_PULSE_WIDTH + 1);
    localparam int HOLD_MAX = (LONG_PRESS > REPEAT_INTERVAL) ? LONG_PRESS : REPEAT_INTERVAL;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic              IDLE_LVL  = (IN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic              REP_EN    = (REPEAT_INTERVAL > 0) ? 1'b1 : 1'b0;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(MIN_PULSE_WIDTH - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_PRESS - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = (REPEAT_INTERVAL > 0) ?
                                              HOLD_W'(REPEAT_INTERVAL - 1) : {HOLD_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_LONG = 2'd2
    } hold_st_e;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic              sync1_r;
        logic              sync2_r;
        logic [DB_W-1:0]   db_cnt_r;
        logic              btn_r;
        logic              press_r;
        logic              release_r;
        logic              long_r;
        logic              repeat_r;
        logic [HOLD_W-1:0] hold_cnt_r;
        hold_st_e          hold_st_r;
        logic              level_s;
        logic              diff_s;
        logic              toggle_s;
        logic              rise_s;
        logic              fall_s;

        // Normalise polarity and detect the edge at which the debounced level flips
        always_comb begin
            level_s = sync2_r ^ IDLE_LVL;
            diff_s  = level_s ^ btn_r;
            if (diff_s && (db_cnt_r == DB_LAST)) begin
                toggle_s = 1'b1;
            end else begin
                toggle_s = 1'b0;
            end
            rise_s = toggle_s & ~btn_r;
            fall_s = toggle_s & btn_r;
        end

        // Synchroniser, debounce counter, debounced level and press/release strobes
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                sync1_r   <= IDLE_LVL;
                sync2_r   <= IDLE_LVL;
                db_cnt_r  <= {DB_W{1'b0}};
                btn_r     <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                sync1_r   <= i_btn[g];
                sync2_r   <= sync1_r;
                press_r   <= rise_s;
                release_r <= fall_s;
                if (!diff_s) begin
                    db_cnt_r <= {DB_W{1'b0}};
                end else if (toggle_s) begin
                    btn_r    <= ~btn_r;
                    db_cnt_r <= {DB_W{1'b0}};
                end else begin
                    db_cnt_r <= db_cnt_r + DB_W'(1'b1);
                end
            end
        end

        // Hold FSM; a debounced fall wins over any threshold reached on the same edge
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                hold_st_r  <= ST_IDLE;
                hold_cnt_r <= {HOLD_W{1'b0}};
                long_r     <= 1'b0;
                repeat_r   <= 1'b0;
            end else begin
                long_r   <= 1'b0;
                repeat_r <= 1'b0;
                if (fall_s) begin
                    hold_st_r  <= ST_IDLE;
                    hold_cnt_r <= {HOLD_W{1'b0}};
                end else begin
                    case (hold_st_r)
                        ST_IDLE: begin
                            hold_cnt_r <= {HOLD_W{1'b0}};
                            if (rise_s) begin
                                hold_st_r <= ST_HOLD;
                            end else begin
                                hold_st_r <= ST_IDLE;
                            end
                        end
                        ST_HOLD: begin
                            if (hold_cnt_r == LONG_LAST) begin
                                long_r     <= 1'b1;
                                hold_st_r  <= ST_LONG;
                                hold_cnt_r <= {HOLD_W{1'b0}};
                            end else if (btn_r) begin
                                hold_cnt_r <= hold_cnt_r + HOLD_W'(1'b1);
                            end else begin
                                hold_cnt_r <= {HOLD_W{1'b0}};
                            end
                        end
                        ST_LONG: begin
                            if (!REP_EN) begin
                                hold_cnt_r <= {HOLD_W{1'b0}};
                            end else if (hold_cnt_r == REP_LAST) begin
                                repeat_r   <= 1'b1;
                                hold_cnt_r <= {HOLD_W{1'b0}};
                            end else begin
                                hold_cnt_r <= hold_cnt_r + HOLD_W'(1'b1);
                            end
                        end
                        default: begin
                            hold_st_r  <= ST_IDLE;
                            hold_cnt_r <= {HOLD_W{1'b0}};
                        end
                    endcase
                end
            end
        end

        assign o_btn[g]     = btn_r;
        assign o_press[g]   = press_r;
        assign o_release[g] = release_r;
        assign o_long[g]    = long_r;
        assign o_repeat[g]  = repeat_r;
    end

    assign o_any = |o_btn;

    btn_input_ctrl_chk #(
        .NUM_CH (NUM_CH)
    ) u_chk (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .o_btn     (o_btn),
        .o_press   (o_press),
        .o_release (o_release),
        .o_long    (o_long),
        .o_repeat  (o_repeat)
    );
endmodule

// File: tb/tb_btn_input_ctrl.sv
// Directed bench for btn_input_ctrl: one build with repeat enabled, one with repeat disabled,
// both fed the same pins. Outputs are sampled 1 ns after each rising edge.

module tb_btn_input_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn = 2'b11;

    logic [1:0] o_btn, o_press, o_release, o_long, o_repeat;
    logic       o_any;
    logic [1:0] d0_btn, d0_press, d0_release, d0_long, d0_repeat;
    logic       d0_any;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int n_press[2] = '{0, 0};
    int n_rel[2]   = '{0, 0};
    int n_long[2]  = '{0, 0};
    int n_rep[2]   = '{0, 0};
    int n0_rep     = 0;

    always #5 clk = ~clk;

    btn_input_ctrl #(
        .NUM_CH(2), .MIN_PULSE_WIDTH(4), .IN_ACTIVE_LOW(1), .LONG_PRESS(10), .REPEAT_INTERVAL(3)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_btn(btn),
        .o_btn(o_btn), .o_press(o_press), .o_release(o_release),
        .o_long(o_long), .o_repeat(o_repeat), .o_any(o_any)
    );

    btn_input_ctrl #(
        .NUM_CH(2), .MIN_PULSE_WIDTH(4), .IN_ACTIVE_LOW(1), .LONG_PRESS(10), .REPEAT_INTERVAL(0)
    ) dut0 (
        .i_clk(clk), .i_rst(rst), .i_btn(btn),
        .o_btn(d0_btn), .o_press(d0_press), .o_release(d0_release),
        .o_long(d0_long), .o_repeat(d0_repeat), .o_any(d0_any)
    );

    // Strobe tallies, taken mid-cycle where every strobe is stable
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (o_press[c] === 1'b1)   n_press[c]++;
            if (o_release[c] === 1'b1) n_rel[c]++;
            if (o_long[c] === 1'b1)    n_long[c]++;
            if (o_repeat[c] === 1'b1)  n_rep[c]++;
        end
        if (d0_repeat !== 2'b00) n0_rep++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state and quiet release of reset
        tick(2);
        chk("rst_btn", {30'd0, o_btn}, 32'd0);
        chk("rst_strobes", {24'd0, o_press, o_release, o_long, o_repeat}, 32'd0);
        chk("rst_any", {31'd0, o_any}, 32'd0);
        rst = 1'b0;
        tick(8);
        chk("idle_btn", {30'd0, o_btn}, 32'd0);
        chk("idle_press_cnt", n_press[0] + n_press[1] + n_rel[0] + n_rel[1], 32'd0);

        // 1: basic press on channel 0, then early release
        btn[0] = 1'b0;
        tick(5);
        chk("t1_pre_btn", {30'd0, o_btn}, 32'd0);
        tick(1);
        chk("t1_btn", {30'd0, o_btn}, 32'd1);
        chk("t1_press", {30'd0, o_press}, 32'd1);
        chk("t1_any", {31'd0, o_any}, 32'd1);
        chk("t1_d0_press", {30'd0, d0_press}, 32'd1);
        tick(1);
        chk("t1_press_low", {30'd0, o_press}, 32'd0);
        chk("t1_btn_hold", {30'd0, o_btn}, 32'd1);
        chk("t1_any_hold", {31'd0, o_any}, 32'd1);
        btn[0] = 1'b1;
        tick(5);
        chk("t1_rel_pre", {30'd0, o_btn}, 32'd1);
        tick(1);
        chk("t1_release", {30'd0, o_release}, 32'd1);
        chk("t1_rel_btn", {30'd0, o_btn}, 32'd0);
        chk("t1_rel_any", {31'd0, o_any}, 32'd0);

        // 2: 3-cycle glitch rejected, 4-cycle pulse accepted
        btn[0] = 1'b0;
        tick(3);
        btn[0] = 1'b1;
        tick(10);
        chk("t2_glitch_btn", {30'd0, o_btn}, 32'd0);
        chk("t2_glitch_press", n_press[0], 32'd1);
        chk("t2_glitch_rel", n_rel[0], 32'd1);
        btn[0] = 1'b0;
        tick(4);
        btn[0] = 1'b1;
        tick(2);
        chk("t2_min_press", {30'd0, o_press}, 32'd1);
        tick(4);
        chk("t2_min_release", {30'd0, o_release}, 32'd1);

        // 3: 40-cycle hold with long press and repeats; repeat on the release edge suppressed
        btn[0] = 1'b0;
        tick(6);
        chk("t3_press", {30'd0, o_press}, 32'd1);
        tick(9);
        chk("t3_long_early", {30'd0, o_long}, 32'd0);
        tick(1);
        chk("t3_long", {30'd0, o_long}, 32'd1);
        chk("t3_rep_at_long", {30'd0, o_repeat}, 32'd0);
        tick(3);
        chk("t3_rep1", {30'd0, o_repeat}, 32'd1);
        tick(1);
        chk("t3_rep1_low", {30'd0, o_repeat}, 32'd0);
        tick(2);
        chk("t3_rep2", {30'd0, o_repeat}, 32'd1);
        tick(3);
        chk("t3_rep3", {30'd0, o_repeat}, 32'd1);
        tick(15);
        btn[0] = 1'b1;
        tick(6);
        chk("t3_release", {30'd0, o_release}, 32'd1);
        chk("t3_rep_suppressed", {30'd0, o_repeat}, 32'd0);
        chk("t3_btn_low", {30'd0, o_btn}, 32'd0);
        tick(10);
        chk("t3_rep_cnt", n_rep[0], 32'd9);
        chk("t3_long_cnt", n_long[0], 32'd1);
        chk("t3_rel_cnt", n_rel[0], 32'd3);

        // 4: two channels offset by 2 cycles
        btn = 2'b10;
        tick(2);
        btn = 2'b00;
        tick(4);
        chk("t4_press0", {30'd0, o_press}, 32'd1);
        tick(2);
        chk("t4_press1", {30'd0, o_press}, 32'd2);
        chk("t4_btn_both", {30'd0, o_btn}, 32'd3);
        tick(8);
        chk("t4_long0", {30'd0, o_long}, 32'd1);
        tick(2);
        chk("t4_long1", {30'd0, o_long}, 32'd2);
        tick(1);
        chk("t4_rep0", {30'd0, o_repeat}, 32'd1);
        tick(2);
        chk("t4_rep1", {30'd0, o_repeat}, 32'd2);
        btn = 2'b01;
        tick(6);
        chk("t4_rel0_btn", {30'd0, o_btn}, 32'd2);
        chk("t4_rel0", {30'd0, o_release}, 32'd1);
        chk("t4_rel0_rep1", {30'd0, o_repeat}, 32'd2);
        chk("t4_any_one", {31'd0, o_any}, 32'd1);
        btn = 2'b11;
        tick(5);
        chk("t4_any_before", {31'd0, o_any}, 32'd1);
        tick(1);
        chk("t4_rel1_btn", {30'd0, o_btn}, 32'd0);
        chk("t4_rel1", {30'd0, o_release}, 32'd2);
        chk("t4_rel1_norep", {30'd0, o_repeat}, 32'd0);
        chk("t4_any_none", {31'd0, o_any}, 32'd0);
        tick(2);
        chk("t4_rep_cnt0", n_rep[0], 32'd12);
        chk("t4_rep_cnt1", n_rep[1], 32'd4);
        chk("t4_long_cnt1", n_long[1], 32'd1);

        // 5: debounced fall lands on the long-press threshold edge
        btn[0] = 1'b0;
        tick(10);
        btn[0] = 1'b1;
        tick(6);
        chk("t5_release", {30'd0, o_release}, 32'd1);
        chk("t5_no_long", {30'd0, o_long}, 32'd0);
        chk("t5_btn", {30'd0, o_btn}, 32'd0);
        chk("t5_fsm_idle", {30'd0, dut.g_ch[0].hold_st_r}, 32'd0);
        tick(5);
        chk("t5_long_cnt", n_long[0], 32'd2);

        // 6: reset mid-press, re-qualification, repeat-disabled build
        btn[0] = 1'b0;
        tick(6);
        chk("t6_press", {30'd0, o_press}, 32'd1);
        tick(12);
        rst = 1'b1;
        #1;
        chk("t6_async_btn", {30'd0, o_btn}, 32'd0);
        chk("t6_async_strobes", {24'd0, o_press, o_release, o_long, o_repeat}, 32'd0);
        chk("t6_async_any", {31'd0, o_any}, 32'd0);
        chk("t6_async_d0", {30'd0, d0_btn}, 32'd0);
        tick(2);
        @(negedge clk);
        rst = 1'b0;
        tick(5);
        chk("t6_requal_pre", {30'd0, o_btn}, 32'd0);
        tick(1);
        chk("t6_repress", {30'd0, o_press}, 32'd1);
        chk("t6_repress_d0", {30'd0, d0_press}, 32'd1);
        tick(9);
        chk("t6_d0_long_early", {30'd0, d0_long}, 32'd0);
        tick(1);
        chk("t6_long", {30'd0, o_long}, 32'd1);
        chk("t6_d0_long", {30'd0, d0_long}, 32'd1);
        tick(3);
        chk("t6_rep", {30'd0, o_repeat}, 32'd1);
        chk("t6_d0_norep", {30'd0, d0_repeat}, 32'd0);
        tick(10);
        btn[0] = 1'b1;
        tick(10);
        chk("t6_d0_btn_low", {30'd0, d0_btn}, 32'd0);
        chk("t6_d0_rep_cnt", n0_rep, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
